// File: rtl/m_alu_execute.sv
// m_alu_execute: two-stage pipelined ALU execute unit.
//
// Stage 1 shifts operand B, then applies the pre-unary ops to A and B.
// Stage 2 runs the core op, applies the post-unary op and forms the flags.
// The stage 2 registers drive the outputs directly.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid / in_ready  upstream handshake
//   in_control           s_control bundle from the ALU decoder
//   in_a, in_b           32-bit operands
//   out_valid / out_ready downstream handshake
//   out_result           32-bit result
//   out_flags            {N, Z, C, V}
//   out_invalid          transaction carried an invalid or unlisted core op
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holding valid keeps its payload stable until that transfer.
// in_ready depends combinationally on out_ready, so a full pipe can drain,
// shift and accept in the same cycle.

package m_alu_pkg;
  typedef enum logic [3:0] {
    CORE_OP_ADD     = 4'd0,
    CORE_OP_AND     = 4'd1,
    CORE_OP_XOR     = 4'd2,
    CORE_OP_SHL     = 4'd3,
    CORE_OP_ASL     = 4'd4,
    CORE_OP_SHR     = 4'd5,
    CORE_OP_ASR     = 4'd6,
    CORE_OP_ROR     = 4'd7,
    CORE_OP_ROL     = 4'd8,
    CORE_OP_INVALID = 4'd15
  } core_op_e;

  typedef enum logic [1:0] {
    UNARY_OP_ID  = 2'd0,
    UNARY_OP_NOT = 2'd1,
    UNARY_OP_NEG = 2'd2
  } unary_op_e;

  typedef enum logic [1:0] {
    SHIFT_SHL = 2'd0,
    SHIFT_SHR = 2'd1,
    SHIFT_ASR = 2'd2,
    SHIFT_ROR = 2'd3
  } shift_kind_e;

  typedef struct packed {
    shift_kind_e kind;
    logic [4:0]  amt;
  } s_shift;

  typedef struct packed {
    core_op_e  op;
    unary_op_e unary_a;
    unary_op_e unary_b;
    s_shift    shift;
    unary_op_e unary_res;
  } s_control;
endpackage

module m_alu_execute
  import m_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  s_control    in_control,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags,
  output logic        out_invalid
);

  function automatic logic [31:0] apply_unary(unary_op_e u, logic [31:0] x);
    case (u)
      UNARY_OP_NOT: apply_unary = ~x;
      UNARY_OP_NEG: apply_unary = ~x + 32'd1;
      default:      apply_unary = x;  // unused encoding behaves as identity
    endcase
  endfunction

  // Rotates use a doubled word so a zero amount needs no special case.
  function automatic logic [31:0] rot_right(logic [31:0] x, logic [4:0] n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] rot_left(logic [31:0] x, logic [4:0] n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

  function automatic logic [31:0] shift_b(shift_kind_e k, logic [31:0] x, logic [4:0] n);
    case (k)
      SHIFT_SHL: shift_b = x << n;
      SHIFT_SHR: shift_b = x >> n;
      SHIFT_ASR: shift_b = $unsigned($signed(x) >>> n);
      default:   shift_b = rot_right(x, n);
    endcase
  endfunction

  // Stage 1 registers
  logic        s1_valid;
  logic [31:0] s1_a;
  logic [31:0] s1_b;
  core_op_e    s1_op;
  unary_op_e   s1_ures;

  // Stage 2 registers (these are the outputs)
  logic        s2_valid;
  logic [31:0] s2_result;
  logic [3:0]  s2_flags;
  logic        s2_invalid;

  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_flags   = s2_flags;
  assign out_invalid = s2_invalid;

  // Stage 1 combinational operand prep
  logic [31:0] b_sh;
  logic [31:0] a1;
  logic [31:0] b1;

  always_comb begin
    b_sh = shift_b(in_control.shift.kind, in_b, in_control.shift.amt);
    a1   = apply_unary(in_control.unary_a, in_a);
    b1   = apply_unary(in_control.unary_b, b_sh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= CORE_OP_ADD;
      s1_ures  <= UNARY_OP_ID;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= a1;
        s1_b    <= b1;
        s1_op   <= in_control.op;
        s1_ures <= in_control.unary_res;
      end
    end
  end

  // Stage 2 combinational core + post-unary
  logic [32:0] sum;
  logic [31:0] core_r;
  logic [31:0] res;
  logic        add_c;
  logic        add_v;
  logic        is_inv;
  logic [3:0]  flags;

  always_comb begin
    sum    = {1'b0, s1_a} + {1'b0, s1_b};
    core_r = '0;
    add_c  = 1'b0;
    add_v  = 1'b0;
    is_inv = 1'b0;
    case (s1_op)
      CORE_OP_ADD: begin
        core_r = sum[31:0];
        add_c  = sum[32];
        add_v  = (s1_a[31] == s1_b[31]) && (sum[31] != s1_a[31]);
      end
      CORE_OP_AND: core_r = s1_a & s1_b;
      CORE_OP_XOR: core_r = s1_a ^ s1_b;
      CORE_OP_SHL,
      CORE_OP_ASL: core_r = s1_a << s1_b[4:0];
      CORE_OP_SHR: core_r = s1_a >> s1_b[4:0];
      CORE_OP_ASR: core_r = $unsigned($signed(s1_a) >>> s1_b[4:0]);
      CORE_OP_ROR: core_r = rot_right(s1_a, s1_b[4:0]);
      CORE_OP_ROL: core_r = rot_left(s1_a, s1_b[4:0]);
      default:     is_inv = 1'b1;
    endcase
    // C and V come from the adder; N and Z see the post-unary result.
    res   = is_inv ? 32'd0 : apply_unary(s1_ures, core_r);
    flags = is_inv ? 4'd0 : {res[31], (res == 32'd0), add_c, add_v};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_flags   <= '0;
      s2_invalid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result  <= res;
        s2_flags   <= flags;
        s2_invalid <= is_inv;
      end
    end
  end

endmodule

// File: tb/tb_m_alu_execute.sv
module tb_m_alu_execute;
  import m_alu_pkg::*;

  localparam int W = 37;  // {invalid, flags[3:0], result[31:0]}

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  s_control    in_control = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        out_invalid;

  m_alu_execute dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_control  (in_control),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .out_invalid (out_invalid)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp = '0;
  int n_acc = 0;
  int n_out = 0;
  logic held = 1'b0;
  logic [W-1:0] held_val = '0;
  logic [W-1:0] obs;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic s_control mk(core_op_e op, unary_op_e ua, unary_op_e ub,
                                  shift_kind_e k, int amt, unary_op_e ur);
    s_control c;
    c.op         = op;
    c.unary_a    = ua;
    c.unary_b    = ub;
    c.shift.kind = k;
    c.shift.amt  = 5'(amt);
    c.unary_res  = ur;
    return c;
  endfunction

  function automatic logic [W-1:0] ev(logic [3:0] f, logic [31:0] r);
    return {1'b0, f, r};
  endfunction

  // reference model: bit-at-a-time shifts, subtraction-based negate
  function automatic logic [31:0] m_un(unary_op_e u, logic [31:0] x);
    if (u == UNARY_OP_NOT) return ~x;
    if (u == UNARY_OP_NEG) return 32'd0 - x;
    return x;
  endfunction

  function automatic logic [W-1:0] model(s_control c, logic [31:0] a, logic [31:0] b);
    logic [31:0] bs, a1, b1, r, res;
    logic [32:0] wide;
    logic cy, ov, bad;
    bs = b;
    for (int k = 0; k < int'(c.shift.amt); k++) begin
      case (c.shift.kind)
        SHIFT_SHL: bs = {bs[30:0], 1'b0};
        SHIFT_SHR: bs = {1'b0, bs[31:1]};
        SHIFT_ASR: bs = {bs[31], bs[31:1]};
        default:   bs = {bs[0], bs[31:1]};
      endcase
    end
    a1 = m_un(c.unary_a, a);
    b1 = m_un(c.unary_b, bs);
    r = a1; cy = 1'b0; ov = 1'b0; bad = 1'b0;
    case (c.op)
      CORE_OP_ADD: begin
        wide = {1'b0, a1} + {1'b0, b1};
        r = wide[31:0]; cy = wide[32];
        ov = (a1[31] == b1[31]) && (r[31] != a1[31]);
      end
      CORE_OP_AND: r = a1 & b1;
      CORE_OP_XOR: r = a1 ^ b1;
      CORE_OP_SHL, CORE_OP_ASL: for (int k = 0; k < int'(b1[4:0]); k++) r = {r[30:0], 1'b0};
      CORE_OP_SHR: for (int k = 0; k < int'(b1[4:0]); k++) r = {1'b0, r[31:1]};
      CORE_OP_ASR: for (int k = 0; k < int'(b1[4:0]); k++) r = {r[31], r[31:1]};
      CORE_OP_ROR: for (int k = 0; k < int'(b1[4:0]); k++) r = {r[0], r[31:1]};
      CORE_OP_ROL: for (int k = 0; k < int'(b1[4:0]); k++) r = {r[30:0], r[31]};
      default: bad = 1'b1;
    endcase
    if (bad) return {1'b1, 4'd0, 32'd0};
    res = m_un(c.unary_res, r);
    return {1'b0, res[31], (res == 32'd0), cy, ov, res};
  endfunction

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    obs = {out_invalid, out_flags, out_result};
    if (held) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", obs, held_val);
    end
    held     = out_valid && !out_ready && !rst;
    held_val = obs;
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      n_acc++;
    end
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check("spurious_out", exp_q.size(), 1);
      else check("result", obs, exp_q.pop_front());
    end
  end

  // driver: call at posedge+1; returns at posedge+1 after acceptance
  task automatic send(input s_control c, input logic [31:0] a, input logic [31:0] b,
                      input logic [W-1:0] e);
    int n;
    n = 0;
    in_valid = 1'b1; in_control = c; in_a = a; in_b = b; cur_exp = e;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  logic bp_done = 1'b0;
  int base;

  initial begin
    s_control c_add;
    c_add = mk(CORE_OP_ADD, UNARY_OP_ID, UNARY_OP_ID, SHIFT_SHL, 0, UNARY_OP_ID);

    // reset state
    tick(3);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", out_result, 0);
    check("rst_flags", out_flags, 0);
    check("rst_invalid", out_invalid, 0);

    // ADD 5+3 with latency check
    send(c_add, 32'd5, 32'd3, ev(4'b0000, 32'd8));
    check("lat_early", out_valid, 0);
    tick(1);
    check("lat_valid", out_valid, 1);
    check("lat_result", out_result, 32'd8);
    wait_drain();

    // SUB form and carry case
    send(mk(CORE_OP_ADD, UNARY_OP_ID, UNARY_OP_NEG, SHIFT_SHL, 0, UNARY_OP_ID),
         32'd3, 32'd5, ev(4'b1000, 32'hFFFF_FFFE));
    send(c_add, 32'h7FFF_FFFF, 32'hFFFF_FFFF, ev(4'b0010, 32'h7FFF_FFFE));
    // signed overflow
    send(c_add, 32'h7FFF_FFFF, 32'd1, ev(4'b1001, 32'h8000_0000));
    // OR form
    send(mk(CORE_OP_AND, UNARY_OP_NOT, UNARY_OP_NOT, SHIFT_SHL, 0, UNARY_OP_NOT),
         32'hF0, 32'h0F, ev(4'b0000, 32'hFF));
    // operand shift SHL/4
    send(mk(CORE_OP_ADD, UNARY_OP_ID, UNARY_OP_ID, SHIFT_SHL, 4, UNARY_OP_ID),
         32'd1, 32'd1, ev(4'b0000, 32'h11));
    // core ROR
    send(mk(CORE_OP_ROR, UNARY_OP_ID, UNARY_OP_ID, SHIFT_SHL, 0, UNARY_OP_ID),
         32'd1, 32'd1, ev(4'b1000, 32'h8000_0000));
    // ASR/31 on B feeds an ADD with a=0
    send(mk(CORE_OP_ADD, UNARY_OP_ID, UNARY_OP_ID, SHIFT_ASR, 31, UNARY_OP_ID),
         32'd0, 32'h8000_0000, ev(4'b1000, 32'hFFFF_FFFF));
    // XOR to zero sets Z
    send(mk(CORE_OP_XOR, UNARY_OP_ID, UNARY_OP_ID, SHIFT_SHL, 0, UNARY_OP_ID),
         32'h1234_5678, 32'h1234_5678, ev(4'b0100, 32'd0));
    // invalid op then ADD 2+2
    send(mk(CORE_OP_INVALID, UNARY_OP_ID, UNARY_OP_ID, SHIFT_SHL, 0, UNARY_OP_NOT),
         32'd9, 32'd9, {1'b1, 4'd0, 32'd0});
    send(c_add, 32'd2, 32'd2, ev(4'b0000, 32'd4));
    wait_drain();

    // backpressure: three back-to-back with the output stalled
    out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        send(c_add, 32'd10, 32'd1, ev(4'b0000, 32'd11));
        send(c_add, 32'd20, 32'd2, ev(4'b0000, 32'd22));
        send(c_add, 32'd30, 32'd3, ev(4'b0000, 32'd33));
        bp_done = 1'b1;
      end
    join_none
    repeat (5) @(negedge clk);
    check("bp_accepts", n_acc - base, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head", {out_invalid, out_flags, out_result}, ev(4'b0000, 32'd11));
    @(posedge clk); #1;
    out_ready = 1'b1;
    base = n_out;
    begin
      int n;
      n = 0;
      while (!bp_done && n < 100) begin
        n++;
        @(posedge clk); #1;
      end
      check("bp_done", bp_done, 1);
    end
    wait_drain();
    check("bp_outputs", n_out - base, 3);

    // reset with both stages full
    out_ready = 1'b0;
    send(c_add, 32'd100, 32'd1, ev(4'b0000, 32'd101));
    send(c_add, 32'd200, 32'd1, ev(4'b0000, 32'd201));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    check("rst2_out_valid", out_valid, 0);
    check("rst2_in_ready", in_ready, 1);
    check("rst2_result", out_result, 0);
    check("rst2_flags", out_flags, 0);
    out_ready = 1'b1;
    base = n_out;
    send(c_add, 32'd7, 32'd1, ev(4'b0000, 32'd8));
    wait_drain();
    tick(3);
    check("rst2_outputs", n_out - base, 1);

    // random traffic with random backpressure
    fork
      repeat (120) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      s_control c;
      logic [31:0] a, b;
      logic [3:0] op_v;
      op_v = 4'($urandom_range(0, 10));
      if (op_v == 4'd10) op_v = 4'd15;
      c = mk(core_op_e'(op_v), unary_op_e'(2'($urandom_range(0, 2))),
             unary_op_e'(2'($urandom_range(0, 2))), shift_kind_e'(2'($urandom_range(0, 3))),
             $urandom_range(0, 31), unary_op_e'(2'($urandom_range(0, 2))));
      case ($urandom_range(0, 4))
        0: a = 32'h8000_0000;
        1: a = 32'h7FFF_FFFF;
        2: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      send(c, a, b, model(c, a, b));
      tick($urandom_range(0, 1));
    end
    tick(130);
    out_ready = 1'b1;
    wait_drain();
    tick(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
